// File: rtl/blackjack_pkg.sv
// Shared state, result and target types plus card constants for the blackjack round controller.
package blackjack_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StClear,
    StFetch,
    StDeal,
    StReady,
    StSettle,
    StPWait,
    StDCheck,
    StCmp,
    StCmpWait,
    StDone,
    StError
  } ctrl_state_t;

  typedef enum logic [1:0] {
    ResNone   = 2'b00,
    ResPlayer = 2'b01,
    ResDealer = 2'b10,
    ResTie    = 2'b11
  } result_t;

  typedef enum logic {
    TgtPlayer = 1'b0,
    TgtDealer = 1'b1
  } target_t;

  localparam int unsigned NUM_INIT_CARDS = 4;
  localparam int unsigned MAX_CARD       = 10;

  // Ace arrives as 0 and counts as 1; face cards 11..15 count as 10.
  function automatic logic [3:0] clamp_card(input logic [3:0] card);
    logic [3:0] val;
    val = card;
    if (card == 4'd0) begin
      val = 4'd1;
    end else if (card > 4'(MAX_CARD)) begin
      val = 4'(MAX_CARD);
    end
    return val;
  endfunction

endpackage

// File: rtl/deal_seq.sv
// Single-card dealer: fetches one card from the deck, presents it to alu_logic and waits for
// the sums to settle. Reports done in the last settle cycle so the round FSM can chain cards.
module deal_seq
  import blackjack_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  target_t    target,
  input  logic       card_valid,
  input  logic [3:0] card_in,
  output logic       card_req,
  output logic       deal_player,
  output logic       deal_dealer,
  output logic       card_ready,
  output logic [3:0] card_value,
  output logic       done,
  output logic       timeout
);

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] FetchLast  = 8'(FETCH_TIMEOUT - 1);

  ctrl_state_t phase_q;
  target_t     tgt_q;
  logic [3:0]  settle_cnt_q;
  logic [7:0]  wait_cnt_q;
  logic        card_req_q;
  logic        deal_player_q;
  logic        deal_dealer_q;
  logic        card_ready_q;
  logic [3:0]  card_q;

  // Combinational so the next FETCH can start on the same edge the decision is made.
  assign done    = (phase_q == StSettle) && (settle_cnt_q == SettleLast);
  assign timeout = (phase_q == StFetch) && !card_valid && (wait_cnt_q == FetchLast);

  assign card_req    = card_req_q;
  assign deal_player = deal_player_q;
  assign deal_dealer = deal_dealer_q;
  assign card_ready  = card_ready_q;
  assign card_value  = card_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q       <= StIdle;
      tgt_q         <= TgtPlayer;
      settle_cnt_q  <= '0;
      wait_cnt_q    <= '0;
      card_req_q    <= 1'b0;
      deal_player_q <= 1'b0;
      deal_dealer_q <= 1'b0;
      card_ready_q  <= 1'b0;
      card_q        <= '0;
    end else begin
      deal_player_q <= 1'b0;
      deal_dealer_q <= 1'b0;
      card_ready_q  <= 1'b0;
      case (phase_q)
        StIdle: begin
          if (go) begin
            phase_q    <= StFetch;
            tgt_q      <= target;
            wait_cnt_q <= '0;
            card_req_q <= 1'b1;
          end
        end
        StFetch: begin
          if (card_valid) begin
            phase_q       <= StDeal;
            card_req_q    <= 1'b0;
            card_q        <= clamp_card(card_in);
            deal_player_q <= (tgt_q == TgtPlayer);
            deal_dealer_q <= (tgt_q == TgtDealer);
          end else if (wait_cnt_q == FetchLast) begin
            phase_q    <= StIdle;
            card_req_q <= 1'b0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        StDeal: begin
          phase_q      <= StReady;
          card_ready_q <= 1'b1;
        end
        StReady: begin
          phase_q      <= StSettle;
          settle_cnt_q <= '0;
        end
        StSettle: begin
          if (done) begin
            if (go) begin
              phase_q    <= StFetch;
              tgt_q      <= target;
              wait_cnt_q <= '0;
              card_req_q <= 1'b1;
            end else begin
              phase_q <= StIdle;
            end
          end else begin
            settle_cnt_q <= settle_cnt_q + 4'd1;
          end
        end
        default: phase_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/blackjack_ctrl.sv
// Round sequencer: initial deal, player hit/stand turn, dealer auto-hit loop and compare.
// Card movement is delegated to deal_seq; this FSM sits in StFetch while a card is in flight.
module blackjack_ctrl
  import blackjack_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       hit_btn,
  input  logic       stand_btn,
  output logic       card_req,
  input  logic       card_valid,
  input  logic [3:0] card_in,
  output logic       clear_sums,
  output logic       deal_player,
  output logic       deal_dealer,
  output logic       card_ready,
  output logic       compare,
  output logic       stand_active,
  output logic [3:0] card_value,
  input  logic       player_bust,
  input  logic       dealer_bust,
  input  logic       dealer_auto_hit,
  input  logic       player_win,
  input  logic       dealer_win,
  input  logic       tie,
  output logic       round_done,
  output logic [1:0] result,
  output logic       error
);

  localparam logic [2:0] InitCards = 3'(NUM_INIT_CARDS);

  ctrl_state_t state_q;
  logic [2:0]  deal_cnt_q;
  target_t     tgt_q;
  result_t     result_q;
  logic        clear_sums_q;
  logic        compare_q;
  logic        stand_active_q;
  logic        round_done_q;
  logic        error_q;

  logic        go;
  target_t     go_tgt;
  logic        seq_done;
  logic        seq_timeout;
  logic        initial_deal;

  assign initial_deal = deal_cnt_q < InitCards;

  assign clear_sums   = clear_sums_q;
  assign compare      = compare_q;
  assign stand_active = stand_active_q;
  assign round_done   = round_done_q;
  assign result       = result_q;
  assign error        = error_q;

  // Card launch decision; the FSM below follows go into StFetch.
  always_comb begin
    go     = 1'b0;
    go_tgt = TgtPlayer;
    case (state_q)
      StClear: go = 1'b1;
      StFetch: begin
        if (seq_done && initial_deal && ((deal_cnt_q + 3'd1) < InitCards)) begin
          go     = 1'b1;
          // Next card index is deal_cnt+1; odd indices go to the dealer.
          go_tgt = deal_cnt_q[0] ? TgtPlayer : TgtDealer;
        end
      end
      StPWait: go = hit_btn && !stand_btn;
      StDCheck: begin
        if (!dealer_bust && dealer_auto_hit) begin
          go     = 1'b1;
          go_tgt = TgtDealer;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= StIdle;
      deal_cnt_q     <= '0;
      tgt_q          <= TgtPlayer;
      result_q       <= ResNone;
      clear_sums_q   <= 1'b0;
      compare_q      <= 1'b0;
      stand_active_q <= 1'b0;
      round_done_q   <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      clear_sums_q <= 1'b0;
      compare_q    <= 1'b0;
      if (go) tgt_q <= go_tgt;
      case (state_q)
        StIdle, StDone, StError: begin
          if (start_btn) begin
            state_q        <= StClear;
            clear_sums_q   <= 1'b1;
            deal_cnt_q     <= '0;
            result_q       <= ResNone;
            stand_active_q <= 1'b0;
            round_done_q   <= 1'b0;
            error_q        <= 1'b0;
          end
        end
        StClear: state_q <= StFetch;
        StFetch: begin
          if (seq_timeout) begin
            state_q <= StError;
            error_q <= 1'b1;
          end else if (seq_done) begin
            if (initial_deal) deal_cnt_q <= deal_cnt_q + 3'd1;
            if (go) begin
              state_q <= StFetch;
            end else if (initial_deal || (tgt_q == TgtPlayer)) begin
              if (player_bust) begin
                state_q        <= StCmp;
                compare_q      <= 1'b1;
                stand_active_q <= 1'b1;
              end else begin
                state_q <= StPWait;
              end
            end else begin
              state_q <= StDCheck;
            end
          end
        end
        StPWait: begin
          if (stand_btn) begin
            stand_active_q <= 1'b1;
            state_q        <= StDCheck;
          end else if (hit_btn) begin
            state_q <= StFetch;
          end
        end
        StDCheck: begin
          if (go) begin
            state_q <= StFetch;
          end else begin
            state_q        <= StCmp;
            compare_q      <= 1'b1;
            stand_active_q <= 1'b1;
          end
        end
        StCmp: state_q <= StCmpWait;
        StCmpWait: begin
          state_q      <= StDone;
          round_done_q <= 1'b1;
          if (player_win) begin
            result_q <= ResPlayer;
          end else if (dealer_win) begin
            result_q <= ResDealer;
          end else if (tie) begin
            result_q <= ResTie;
          end else begin
            result_q <= ResNone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  deal_seq #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .FETCH_TIMEOUT(FETCH_TIMEOUT)
  ) u_deal_seq (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .target     (go_tgt),
    .card_valid (card_valid),
    .card_in    (card_in),
    .card_req   (card_req),
    .deal_player(deal_player),
    .deal_dealer(deal_dealer),
    .card_ready (card_ready),
    .card_value (card_value),
    .done       (seq_done),
    .timeout    (seq_timeout)
  );

endmodule

// File: tb/tb_blackjack_ctrl.sv
// Directed bench for blackjack_ctrl with a small deck responder and alu_logic sum model.
module tb_blackjack_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_btn, hit_btn, stand_btn;
  logic       card_req, card_valid;
  logic [3:0] card_in;
  logic       clear_sums, deal_player, deal_dealer, card_ready, compare, stand_active;
  logic [3:0] card_value;
  logic       player_bust, dealer_bust, dealer_auto_hit, player_win, dealer_win, tie;
  logic       round_done, error;
  logic [1:0] result;

  blackjack_ctrl #(
    .SETTLE_CYCLES(2),
    .FETCH_TIMEOUT(255)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_btn      (start_btn),
    .hit_btn        (hit_btn),
    .stand_btn      (stand_btn),
    .card_req       (card_req),
    .card_valid     (card_valid),
    .card_in        (card_in),
    .clear_sums     (clear_sums),
    .deal_player    (deal_player),
    .deal_dealer    (deal_dealer),
    .card_ready     (card_ready),
    .compare        (compare),
    .stand_active   (stand_active),
    .card_value     (card_value),
    .player_bust    (player_bust),
    .dealer_bust    (dealer_bust),
    .dealer_auto_hit(dealer_auto_hit),
    .player_win     (player_win),
    .dealer_win     (dealer_win),
    .tie            (tie),
    .round_done     (round_done),
    .result         (result),
    .error          (error)
  );

  logic [14:0] outs;
  assign outs = {card_req, clear_sums, deal_player, deal_dealer, card_ready, compare,
                 stand_active, round_done, error, result, card_value};

  int checks = 0;
  int errors = 0;

  // Deck contents written by the stimulus; deck_idx advanced by the responder.
  logic [3:0] deck [64];
  int         deck_n = 0;
  int         deck_idx = 0;
  logic       deck_en = 1'b0;
  logic       took = 1'b0;

  int psum = 0, dsum = 0;
  int n_ready = 0, n_cmp = 0, deal_n = 0, overlap_bad = 0;
  int tgt_log [64];
  logic last_dealer = 1'b0;

  // Deck responder and alu_logic model, updated 1 time unit after each rising edge.
  initial begin
    card_valid = 1'b0;
    card_in    = 4'd0;
    player_bust = 1'b0; dealer_bust = 1'b0; dealer_auto_hit = 1'b0;
    player_win = 1'b0; dealer_win = 1'b0; tie = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (took) deck_idx++;
      if ((deal_player && deal_dealer) ||
          (32'(clear_sums) + 32'(compare) + 32'(card_ready) > 32'd1)) overlap_bad++;
      if (deal_player === 1'b1 || deal_dealer === 1'b1) begin
        last_dealer = deal_dealer;
        tgt_log[deal_n] = deal_dealer ? 1 : 0;
        deal_n++;
      end
      if (clear_sums === 1'b1) begin
        psum = 0;
        dsum = 0;
      end
      if (card_ready === 1'b1) begin
        n_ready++;
        if (last_dealer) dsum += int'(card_value);
        else psum += int'(card_value);
      end
      if (compare === 1'b1) n_cmp++;
      card_valid = deck_en && (deck_idx < deck_n);
      card_in    = (deck_idx < deck_n) ? deck[deck_idx] : 4'd0;
      took       = (card_req === 1'b1) && card_valid;
      player_bust     = psum > 21;
      dealer_bust     = dsum > 21;
      dealer_auto_hit = dsum < 17;
      player_win      = (psum <= 21) && ((dsum > 21) || (psum > dsum));
      dealer_win      = (psum > 21) || ((dsum <= 21) && (dsum > psum));
      tie             = (psum <= 21) && (dsum <= 21) && (psum == dsum);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic add_card(input logic [3:0] c);
    deck[deck_n] = c;
    deck_n++;
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    tick(1);
    start_btn = 1'b0;
  endtask

  task automatic wait_ready(input int target, input int limit);
    int k = 0;
    while (n_ready < target && k < limit) begin
      tick(1);
      k++;
    end
    check("wait_ready", 32'(n_ready >= target), 32'd1);
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (round_done !== 1'b1 && k < limit) begin
      tick(1);
      k++;
    end
    check("wait_done", 32'(round_done), 32'd1);
  endtask

  // Deal targets since base as a bit pattern, first card in the MSB.
  function automatic logic [31:0] deal_pattern(input int base, input int n);
    logic [31:0] pat = '0;
    for (int i = 0; i < n; i++) pat = (pat << 1) | 32'(tgt_log[base + i]);
    return pat;
  endfunction

  int base_deal, base_ready, base_cmp, base_deck;

  initial begin
    rst = 1'b0; start_btn = 1'b0; hit_btn = 1'b0; stand_btn = 1'b0;
    tick(3);
    check("reset_outputs", 32'(outs), 32'd0);
    rst = 1'b1;
    tick(2);

    // Round 1: 10,9,7,7 then stand; dealer at 16 draws 5 to reach 21.
    add_card(4'd10); add_card(4'd9); add_card(4'd7); add_card(4'd7); add_card(4'd5);
    deck_en = 1'b1;
    base_deal = deal_n; base_ready = n_ready; base_cmp = n_cmp; base_deck = deck_idx;
    press_start();
    check("start_clear", 32'({clear_sums, card_req}), 32'b10);
    tick(1);
    check("start_req", 32'({clear_sums, card_req}), 32'b01);
    tick(1);
    check("deal1_player", 32'({deal_player, deal_dealer, card_value}), 32'h2A);
    tick(1);
    check("deal1_ready", 32'({card_ready, card_value}), 32'h1A);
    tick(3);
    check("card2_req_5cyc", 32'(card_req), 32'd1);
    tick(1);
    check("deal2_dealer", 32'({deal_player, deal_dealer, card_value}), 32'h19);
    wait_ready(base_ready + 4, 60);
    tick(4);
    check("pwait_no_stand", 32'(stand_active), 32'd0);
    press_start();
    check("start_ignored", 32'(clear_sums), 32'd0);
    stand_btn = 1'b1;
    tick(1);
    stand_btn = 1'b0;
    check("stand_set", 32'(stand_active), 32'd1);
    wait_done(100);
    check("r1_result", 32'(result), 32'b10);
    check("r1_deal_order", deal_pattern(base_deal, deal_n - base_deal), 32'b01011);
    check("r1_compare_once", 32'(n_cmp - base_cmp), 32'd1);
    check("r1_cards_used", 32'(deck_idx - base_deck), 32'd5);

    // Round 2: 10,2,10,3 then hit 5 busts the player; no dealer draw.
    add_card(4'd10); add_card(4'd2); add_card(4'd10); add_card(4'd3); add_card(4'd5);
    add_card(4'd9);
    base_deal = deal_n; base_ready = n_ready; base_deck = deck_idx;
    press_start();
    wait_ready(base_ready + 4, 60);
    tick(4);
    hit_btn = 1'b1;
    tick(1);
    hit_btn = 1'b0;
    wait_done(100);
    check("r2_result", 32'(result), 32'b10);
    check("r2_deal_order", deal_pattern(base_deal, deal_n - base_deal), 32'b01010);
    check("r2_cards_used", 32'(deck_idx - base_deck), 32'd5);
    check("r2_stand_on_cmp", 32'(stand_active), 32'd1);

    // Round 3: leftover 9 is discarded by skipping it; 10,9,8,8 with hit+stand together.
    deck_en = 1'b0;
    tick(2);
    deck_n = deck_idx;
    deck_en = 1'b1;
    add_card(4'd10); add_card(4'd9); add_card(4'd8); add_card(4'd8);
    base_deal = deal_n; base_ready = n_ready;
    press_start();
    wait_ready(base_ready + 4, 60);
    tick(4);
    hit_btn = 1'b1;
    stand_btn = 1'b1;
    tick(1);
    hit_btn = 1'b0;
    stand_btn = 1'b0;
    check("hitstand_stand", 32'(stand_active), 32'd1);
    wait_done(100);
    check("r3_deal_count", 32'(deal_n - base_deal), 32'd4);
    check("r3_result", 32'(result), 32'b01);

    // Round 4: 10,10,8,8 stand gives a tie.
    add_card(4'd10); add_card(4'd10); add_card(4'd8); add_card(4'd8);
    base_ready = n_ready;
    press_start();
    wait_ready(base_ready + 4, 60);
    tick(4);
    stand_btn = 1'b1;
    tick(1);
    stand_btn = 1'b0;
    wait_done(100);
    check("r4_tie", 32'(result), 32'b11);

    // Fetch timeout with the deck silent.
    deck_en = 1'b0;
    press_start();
    tick(1);
    check("to_req_start", 32'(card_req), 32'd1);
    tick(254);
    check("to_req_held", 32'({error, card_req}), 32'b01);
    tick(1);
    check("to_error", 32'({error, card_req, round_done}), 32'b100);

    // Restart from ERROR with ace and face cards to check clamping.
    add_card(4'd0); add_card(4'd13); add_card(4'd4); add_card(4'd10);
    deck_en = 1'b1;
    press_start();
    check("restart_clear", 32'({clear_sums, error}), 32'b10);
    tick(2);
    check("clamp0_deal", 32'({deal_player, card_value}), 32'h11);
    tick(1);
    check("clamp0_ready", 32'({card_ready, card_value}), 32'h11);
    tick(4);
    check("clamp13_deal", 32'({deal_dealer, card_value}), 32'h1A);
    tick(1);
    check("clamp13_ready", 32'({card_ready, card_value}), 32'h1A);
    tick(6);
    // Now in the first settle cycle of the third card.
    rst = 1'b0;
    tick(1);
    check("reset_midround", 32'(outs), 32'd0);
    rst = 1'b1;
    hit_btn = 1'b1;
    stand_btn = 1'b1;
    tick(1);
    hit_btn = 1'b0;
    stand_btn = 1'b0;
    tick(3);
    check("idle_ignores_btns", 32'(outs), 32'd0);
    press_start();
    check("post_reset_start", 32'(clear_sums), 32'd1);
    tick(1);
    check("post_reset_req", 32'(card_req), 32'd1);

    check("no_overlap", 32'(overlap_bad), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/blackjack_ctrl.md
# blackjack_ctrl

Round sequencer for the blackjack datapath. Fetches cards from the card source over a valid/request handshake and deals them into `alu_logic` using its deal/card_ready protocol. Runs the initial four-card deal, the player hit/stand turn and the dealer auto-hit loop, then triggers the compare and latches the round result. It sits between the button/deck front end and `alu_logic`.

## Interface
Parameters:
- SETTLE_CYCLES, 2: idle cycles after each card_ready pulse before sums/flags are sampled (1..15)
- FETCH_TIMEOUT, 255: max cycles card_req may stay unanswered before ERROR (1..255)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- start_btn  in  1  one-cycle pulse; starts a round from IDLE, DONE or ERROR
- hit_btn  in  1  one-cycle pulse; honoured only in P_WAIT
- stand_btn  in  1  one-cycle pulse; honoured only in P_WAIT
- card_req  out  1  card request to deck; held until card_valid
- card_valid  in  1  deck handshake; transfer when card_req && card_valid
- card_in  in  4  card from deck
- clear_sums, deal_player, deal_dealer, card_ready, compare, stand_active  out  1 each  `alu_logic` controls
- card_value  out  4  card to `alu_logic`
- player_bust, dealer_bust, dealer_auto_hit, player_win, dealer_win, tie  in  1 each  `alu_logic` status
- round_done  out  1  high while in DONE
- result  out  2  00 none, 01 player, 10 dealer, 11 tie
- error  out  1  high while in ERROR

## Operation
- States: IDLE, CLEAR, FETCH, DEAL, READY, SETTLE, P_WAIT, D_CHECK, CMP, CMP_WAIT, DONE, ERROR.
- IDLE/DONE/ERROR + start_btn -> CLEAR: clear_sums=1 for one cycle, deal_cnt=0, result=00, stand_active=0 -> FETCH with target = player.
- FETCH: card_req=1. On handshake, latch card_in (0 -> 1, 11..15 -> 10) -> DEAL. Timeout counter reaches FETCH_TIMEOUT -> ERROR.
- DEAL: deal_player or deal_dealer per target = 1, card_value = latched card. -> READY.
- READY: card_ready=1, card_value held -> SETTLE.
- SETTLE: SETTLE_CYCLES cycles, then a decision:
  - Initial deal (deal_cnt<4): targets P,D,P,D. Increment deal_cnt. If <4, go to FETCH. Else go to P_WAIT; a player_bust here goes to CMP.
  - Player hit: player_bust goes to CMP, else P_WAIT.
  - Dealer card: goes to D_CHECK.
- P_WAIT: stand_btn sets stand_active=1 and goes to D_CHECK. Otherwise hit_btn goes to FETCH with target player. Simultaneous hit+stand resolves as stand. Buttons are ignored in all other states.
- D_CHECK: dealer_bust goes to CMP. dealer_auto_hit goes to FETCH with target dealer. Otherwise CMP.
- CMP: compare=1 one cycle -> CMP_WAIT (one cycle) -> DONE. On entry to DONE, latch result: player_win 01, dealer_win 10, tie 11, none set 00.
- stand_active: set on stand or on entry to CMP; cleared only by CLEAR/reset.
- start_btn mid-round is ignored.

## Timing
- Reset: state IDLE, counters 0. All outputs 0, result 00, card_value 0.
- start_btn in cycle t gives clear_sums at t+1 and card_req at t+2.
- A card takes FETCH (≥1 cycle) + DEAL 1 + READY 1 + SETTLE_CYCLES. With card_valid already high and SETTLE_CYCLES=2, that is 5 cycles from card_req to decision.
- Every control output is registered and asserted for exactly one cycle except card_req, stand_active, round_done, result and error.
- deal_player and deal_dealer are never high together. clear_sums, compare and card_ready never overlap.
- If reset is asserted mid-round, state returns to IDLE on the next edge. card_req drops and a pending card is discarded.
- The timeout counter resets on every FETCH entry.

## Structure
- Package `blackjack_pkg` holds:
  - state enum `ctrl_state_t`
  - `result_t` (NONE/PLAYER/DEALER/TIE)
  - `target_t`
  - localparams `NUM_INIT_CARDS=4`, `MAX_CARD=10`
- Sub-module `deal_seq` owns FETCH/DEAL/READY/SETTLE, the card latch/clamp and the timeout. Interface: go/target in, done/timeout out.
- Top-level FSM handles round policy.

## Test plan
- Deck supplies 10,9,7,7; stand immediately -> four deal pulses ordered P,D,P,D. With alu_logic, dealer_auto_hit is seen at 16, so the dealer takes the next card (5), giving 21. Then compare pulses once and DONE with result 10.
- Initial 10,2,10,3, then hit with card 5 -> player_bust. CMP is reached without a dealer card fetched, and result is 10.
- hit_btn and stand_btn in the same cycle in P_WAIT -> stand taken: stand_active=1, and no player deal_player pulse follows.
- card_valid withheld for 255 cycles after card_req -> error=1. A later start_btn gives clear_sums and resumes normally.
- card_in=0 and card_in=13 -> card_value 1 and 10 respectively, during DEAL and READY.
- Reset asserted during SETTLE of the third card -> next cycle all outputs 0 and state IDLE. Hit/stand are ignored until start.
